// File: rtl/sine_dds_ctrl.sv
// DDS sequencer: divided tick advances a phase accumulator whose MSBs address a
// registered sine ROM; the ROM word is re-registered as a qualified DAC sample.
module sine_dds_ctrl #(
    parameter int unsigned PHASE_WIDTH   = 24,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DIV_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic [PHASE_WIDTH-1:0]   tune_word,
    input  logic                     tune_load,
    output logic [ADDRESS_WIDTH-1:0] lut_addr,
    input  logic [DATA_WIDTH-1:0]    lut_data,
    output logic [DATA_WIDTH-1:0]    sample,
    output logic                     sample_valid,
    output logic                     wrap,
    output logic                     pending
);

    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] tune_active_q, tune_active_d;
    logic [PHASE_WIDTH-1:0] tune_pend_q, tune_pend_d;
    logic                   pending_q, pending_d;
    logic                   v1_q, v1_d, c1_q, c1_d;
    logic                   v2_q, v2_d, c2_q, c2_d;
    logic [DATA_WIDTH-1:0]  sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   wrap_q, wrap_d;

    logic                   tick;
    logic [PHASE_WIDTH:0]   sum;
    logic                   carry;
    logic                   apply;

    always_comb begin
        tick  = en && (cnt_q == div) && !sync;
        sum   = {1'b0, phase_q} + {1'b0, tune_active_q};
        carry = sum[PHASE_WIDTH];
        // Wrap carry, idle, and sync are the only points where the increment may change.
        apply = (tick && carry) || !en || sync;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sync) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q >= div) cnt_d = '0;
            else              cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        phase_d = phase_q;
        if (sync)      phase_d = '0;
        else if (tick) phase_d = sum[PHASE_WIDTH-1:0];
    end

    always_comb begin
        tune_active_d = tune_active_q;
        tune_pend_d   = tune_pend_q;
        pending_d     = pending_q;
        if (apply) begin
            if (tune_load) begin
                tune_active_d = tune_word;
                tune_pend_d   = tune_word;
                pending_d     = 1'b0;
            end else if (pending_q) begin
                tune_active_d = tune_pend_q;
                pending_d     = 1'b0;
            end
        end else if (tune_load) begin
            tune_pend_d = tune_word;
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        v1_d           = tick;
        c1_d           = tick && carry;
        v2_d           = v1_q && !sync;
        c2_d           = v1_q && c1_q && !sync;
        sample_valid_d = v2_q && !sync;
        wrap_d         = v2_q && c2_q && !sync;
        sample_d       = (v2_q && !sync) ? lut_data : sample_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            phase_q        <= '0;
            tune_active_q  <= '0;
            tune_pend_q    <= '0;
            pending_q      <= 1'b0;
            v1_q           <= 1'b0;
            c1_q           <= 1'b0;
            v2_q           <= 1'b0;
            c2_q           <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            tune_active_q  <= tune_active_d;
            tune_pend_q    <= tune_pend_d;
            pending_q      <= pending_d;
            v1_q           <= v1_d;
            c1_q           <= c1_d;
            v2_q           <= v2_d;
            c2_q           <= c2_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            wrap_q         <= wrap_d;
        end
    end

    assign lut_addr     = phase_q[PHASE_WIDTH-1 -: ADDRESS_WIDTH];
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_sine_dds_ctrl.sv
// Directed bench for sine_dds_ctrl with a registered-read ROM stub.
module tb_sine_dds_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        sync;
    logic [15:0] div;
    logic [23:0] tune_word;
    logic        tune_load;
    logic [7:0]  lut_addr;
    logic [7:0]  lut_data = 8'h00;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        wrap;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    sine_dds_ctrl #(
        .PHASE_WIDTH  (24),
        .ADDRESS_WIDTH(8),
        .DATA_WIDTH   (8),
        .DIV_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sync        (sync),
        .div         (div),
        .tune_word   (tune_word),
        .tune_load   (tune_load),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .wrap        (wrap),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    always @(posedge clk) lut_data <= rom(lut_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sync = 1'b0; tune_load = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Load the tune word while idle (applies at once), then start running.
    task automatic configure(input logic [15:0] d, input logic [23:0] t, input string name);
        div = d; tune_word = t; tune_load = 1'b1; en = 1'b0;
        step();
        tune_load = 1'b0;
        check({name, "_pending_idle"}, 32'(pending), 32'd0);
        en = 1'b1;
    endtask

    task automatic wait_sample(input int k, input logic [7:0] addr, input logic wr,
                               input int cyc, input string name);
        int seen = 0;
        int got  = -1;
        int c    = 0;
        while (c < 4000 && got < 0) begin
            step();
            c++;
            if (sample_valid === 1'b1) begin
                seen++;
                if (seen == k) begin
                    got = c;
                    check({name, "_sample"}, 32'(sample), 32'(rom(addr)));
                    check({name, "_wrap"}, 32'(wrap), 32'(wr));
                end
            end
        end
        check({name, "_cycle"}, 32'(got), 32'(cyc));
    endtask

    typedef struct {
        logic [15:0] div;
        logic [23:0] tune;
        int          k;
        logic [7:0]  addr;
        logic        wrap;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst = 1'b1; en = 1'b0; sync = 1'b0; div = '0; tune_word = '0; tune_load = 1'b0;

        // k-th sample after start: address of tick k, carry of tick k, cycle k*(div+1)+2
        vecs[0] = '{16'd3, 24'h010000,   1, 8'h01, 1'b0,   6};
        vecs[1] = '{16'd3, 24'h010000,   3, 8'h03, 1'b0,  14};
        vecs[2] = '{16'd0, 24'h010000, 256, 8'h00, 1'b1, 258};
        vecs[3] = '{16'd0, 24'h010000, 255, 8'hFF, 1'b0, 257};
        vecs[4] = '{16'd0, 24'h100000,  16, 8'h00, 1'b1,  18};
        vecs[5] = '{16'd1, 24'h030000,   3, 8'h09, 1'b0,   8};
        vecs[6] = '{16'd2, 24'h800000,   2, 8'h00, 1'b1,   8};
        vecs[7] = '{16'd0, 24'h000000,   4, 8'h00, 1'b0,   6};
        vecs[8] = '{16'd4, 24'hFFFFFF,   2, 8'hFF, 1'b1,  12};
        vecs[9] = '{16'd0, 24'h012345,   5, 8'h05, 1'b0,   7};

        do_reset();
        check("rst_addr",    32'(lut_addr),     32'd0);
        check("rst_sample",  32'(sample),       32'd0);
        check("rst_valid",   32'(sample_valid), 32'd0);
        check("rst_wrap",    32'(wrap),         32'd0);
        check("rst_pending", 32'(pending),      32'd0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            configure(vecs[i].div, vecs[i].tune, $sformatf("v%0d", i));
            wait_sample(vecs[i].k, vecs[i].addr, vecs[i].wrap, vecs[i].cyc, $sformatf("v%0d", i));
        end

        // Buffered retune: load 0x200000 while stepping 0x10; applies at the carry tick.
        do_reset();
        configure(16'd0, 24'h100000, "buf");
        for (int j = 1; j <= 18; j++) begin
            int ea;
            step();
            ea = (j <= 16) ? ((j * 16) & 255) : ((j - 16) * 32);
            check($sformatf("buf_addr_%0d", j), 32'(lut_addr), 32'(ea));
            check($sformatf("buf_pend_%0d", j), 32'(pending), (j >= 4 && j < 16) ? 32'd1 : 32'd0);
            if (j == 17) check("buf_wrap_f0", 32'(wrap), 32'd0);
            if (j == 18) begin
                check("buf_wrap_00", 32'(wrap), 32'd1);
                check("buf_sample_00", 32'(sample), 32'(rom(8'h00)));
            end
            if (j == 3) begin
                tune_word = 24'h200000;
                tune_load = 1'b1;
            end
            if (j == 4) tune_load = 1'b0;
        end

        // sync colliding with a tick at phase 0x7F0000, with a pending tune word.
        do_reset();
        configure(16'd0, 24'h010000, "sync");
        for (int j = 1; j <= 131; j++) begin
            step();
            if (j == 120) begin
                tune_word = 24'h020000;
                tune_load = 1'b1;
            end
            if (j == 121) begin
                tune_load = 1'b0;
                check("sync_pend_set", 32'(pending), 32'd1);
            end
            if (j == 127) begin
                check("sync_addr_pre",   32'(lut_addr),     32'h7F);
                check("sync_valid_pre",  32'(sample_valid), 32'd1);
                check("sync_sample_pre", 32'(sample),       32'(rom(8'h7D)));
                sync = 1'b1;
            end
            if (j == 128) begin
                sync = 1'b0;
                check("sync_addr_0",    32'(lut_addr),     32'd0);
                check("sync_valid_128", 32'(sample_valid), 32'd0);
                check("sync_pend_clr",  32'(pending),      32'd0);
                check("sync_hold_128",  32'(sample),       32'(rom(8'h7D)));
            end
            if (j == 129) begin
                check("sync_valid_129", 32'(sample_valid), 32'd0);
                check("sync_addr_129",  32'(lut_addr),     32'h02);
            end
            if (j == 130) begin
                check("sync_valid_130", 32'(sample_valid), 32'd0);
                check("sync_addr_130",  32'(lut_addr),     32'h04);
                check("sync_hold_130",  32'(sample),       32'(rom(8'h7D)));
            end
            if (j == 131) begin
                check("sync_valid_131",  32'(sample_valid), 32'd1);
                check("sync_sample_131", 32'(sample),       32'(rom(8'h02)));
            end
        end

        // Reset one clock after a tick, with an earlier sample already out.
        do_reset();
        configure(16'd3, 24'h010000, "mid");
        for (int j = 1; j <= 11; j++) begin
            step();
            if (j == 6) check("mid_sample_pre", 32'(sample), 32'(rom(8'h01)));
            if (j == 8) rst = 1'b1;
            if (j == 9) begin
                rst = 1'b0;
                en  = 1'b0;
                check("mid_valid",   32'(sample_valid), 32'd0);
                check("mid_sample",  32'(sample),       32'd0);
                check("mid_addr",    32'(lut_addr),     32'd0);
                check("mid_wrap",    32'(wrap),         32'd0);
                check("mid_pending", 32'(pending),      32'd0);
            end
            if (j >= 10) check($sformatf("mid_flush_%0d", j), 32'(sample_valid), 32'd0);
        end
        configure(16'd3, 24'h010000, "restart");
        wait_sample(1, 8'h01, 1'b0, 6, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sine_dds_ctrl.md
Name: sine_dds_ctrl

Overview:
Direct-digital-synthesis sequencer that drives the synchronous sine lookup ROM (1-cycle registered read) used by the R2R sine output path. A divided sample tick advances a phase accumulator. The accumulator MSBs address the ROM, and the ROM output is re-registered as a qualified sample for the R2R DAC stage. The frequency word is double-buffered so that updates take effect glitch-free at phase wrap.

Parameters:
PHASE_WIDTH, 24, accumulator width; must be >= ADDRESS_WIDTH
ADDRESS_WIDTH, 8, ROM address width; matches the ROM's ADDRESS_WIDTH
DATA_WIDTH, 8, ROM data width; matches the ROM's DATA_WIDTH
DIV_WIDTH, 16, sample-tick divider width

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous reset, active-high
en  in  1  run enable; when low, ticks stop and phase holds
sync  in  1  1-cycle pulse; clears phase and divider
div  in  DIV_WIDTH  tick period minus 1 (0 = tick every clk)
tune_word  in  PHASE_WIDTH  phase increment per tick
tune_load  in  1  1-cycle pulse; captures tune_word into the pending register
lut_addr  out  ADDRESS_WIDTH  to ROM addr; equals phase[PHASE_WIDTH-1 -: ADDRESS_WIDTH]
lut_data  in  DATA_WIDTH  from ROM data; valid 1 clk after lut_addr
sample  out  DATA_WIDTH  registered output sample to the DAC
sample_valid  out  1  1-cycle pulse when sample updates
wrap  out  1  high together with sample_valid for the sample whose tick produced accumulator carry-out
pending  out  1  a loaded tune word is waiting to be applied

Behaviour:
- Reset (rst high at a clk edge) clears all of the following, and overrides every other input, including mid-pipeline:
  - phase, divider count, tune_active, tune_pend, pending, sample, sample_valid, wrap
  - all pipeline valid/carry flags
  - result: lut_addr = 0
- Divider:
  - cnt counts 0..div while en=1.
  - tick = en & (cnt == div); on tick, cnt returns to 0.
  - If div changes so that cnt > div, cnt wraps to 0 on the next clock, with no tick that clock.
  - en=0: cnt holds, tick=0.
- Accumulator:
  - On tick: {carry, phase} <= phase + tune_active, modulo 2^PHASE_WIDTH.
  - lut_addr is driven from the phase register, with no combinational path from inputs.
- Tune buffering:
  - tune_load captures tune_word into tune_pend and sets pending=1. A later load before application overwrites tune_pend (last load wins).
  - Apply point 1: a tick whose addition carries out. That tick uses the old tune_active; the new value copies to tune_active at the same edge, and pending clears.
  - Apply point 2: en=0 on the cycle after the load. tune_active updates immediately.
  - tune_load and apply point in the same cycle: the newly loaded word is the one applied; pending stays 0.
- sync:
  - Clears phase and cnt at the next edge, suppresses any tick that same cycle, and flushes the in-flight sample_valid/wrap flags.
  - If pending=1, it also applies tune_pend.
  - sync has priority over tick; rst has priority over sync.
- Pipeline (fixed latency 3), for a tick in cycle n:
  - cycle n+1: phase and lut_addr hold the new value
  - cycle n+2: lut_data is valid
  - cycle n+3: sample = lut_data captured at the end of n+2; sample_valid=1 for exactly one cycle; wrap = carry of tick n
- Throughput: div=0 gives one sample per clk. The pipeline is fully overlapped with no bubbles.
- en deasserted mid-pipeline: in-flight samples still complete; no new ticks are issued.
- sample holds its value between sample_valid pulses.
- tune_active=0: samples repeat the current address; wrap never asserts.

Test Plan:
1. Reset: after rst, div=3, tune_word=0x010000 loaded, then en=1 -> first sample_valid 3 clk after the first tick; ticks every 4 clk; lut_addr sequence 1,2,3,...; sample equals the ROM contents at each address.
2. Latency and throughput: div=0, tune=0x010000 -> sample_valid high every clk; sample(n+3) = ROM[addr after tick n]; addr 0xFF->0x00 asserts wrap on the sample for addr 0x00.
3. Buffered tune: tune=0x100000 running, load 0x200000 mid-cycle -> pending=1; addr steps 0x10 until carry-out; the step after the wrap is 0x20; pending falls at the carry tick edge.
4. Load while idle: en=0, load 0x030000 -> pending is 0 the next clk; after en=1, addr steps 3,6,9.
5. sync priority: assert sync in the same cycle as a tick with phase=0x7F0000 -> phase=0, no sample_valid from that tick, and in-flight valids are flushed.
6. Reset mid-pipeline: rst 1 clk after a tick -> sample_valid stays 0, sample=0, lut_addr=0; normal restart afterwards.
